// File: rtl/nn_bridge_pkg.sv
// Shared types and register-map constants for the NN MMIO bridge.
package nn_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } bridge_state;

  localparam logic [7:0] CTRL_OFS = 8'h00;
  localparam logic [7:0] STAT_OFS = 8'h04;
  localparam logic [7:0] RES_OFS  = 8'h08;
  localparam logic [7:0] IN_OFS   = 8'h10;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

endpackage

// File: rtl/nn_input_buffer.sv
// Input-vector register file: one synchronous write port, two combinational read ports.
module nn_input_buffer #(
  parameter  int unsigned N_IN = 16,
  parameter  int unsigned DW   = 8,
  localparam int unsigned IW   = $clog2(N_IN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] core_idx_i,
  output logic [DW-1:0] core_data_o,
  input  logic [IW-1:0] nn_idx_i,
  output logic [DW-1:0] nn_data_o
);

  logic [DW-1:0] mem_q [N_IN];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_IN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wdata_i;
    end
  end

  assign core_data_o = mem_q[core_idx_i];
  assign nn_data_o   = mem_q[nn_idx_i];

endmodule

// File: rtl/nn_mmio_bridge.sv
// Memory-mapped bridge between the core data bus and the NN engine controller.
module nn_mmio_bridge
  import nn_bridge_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter  int unsigned N_IN      = 16,
  parameter  int unsigned DW        = 8,
  parameter  int unsigned RW        = 32,
  localparam int unsigned IW        = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_we,
  input  logic [31:0]   mem_adr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_sel,
  output logic          nn_start,
  input  logic [IW-1:0] nn_rd_idx,
  output logic [DW-1:0] nn_rd_data,
  input  logic          nn_done,
  input  logic [RW-1:0] nn_result
);

  bridge_state   state_q, state_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic [RW-1:0] result_q, result_d;

  logic [5:0]    word;
  logic [5:0]    in_off;
  logic          in_hit;
  logic [IW-1:0] buf_idx;
  logic [DW-1:0] core_data;
  logic          wr, ctrl_wr, in_wr, buf_we;
  logic          start_cmd, clear_cmd;
  logic [31:0]   status;
  logic          unused_bits;

  assign mem_sel = (mem_adr[31:8] == BASE_ADDR[31:8]);
  assign word    = mem_adr[7:2];
  assign in_off  = word - IN_OFS[7:2];
  assign in_hit  = (word >= IN_OFS[7:2]) && ({26'b0, in_off} < N_IN);
  assign buf_idx = in_off[IW-1:0];

  assign wr        = mem_we && mem_sel;
  assign ctrl_wr   = wr && (word == CTRL_OFS[7:2]);
  assign in_wr     = wr && in_hit;
  // CLEAR takes precedence over START in the same write.
  assign clear_cmd = ctrl_wr && mem_wdata[CTRL_CLEAR];
  assign start_cmd = ctrl_wr && mem_wdata[CTRL_START] && !mem_wdata[CTRL_CLEAR];
  assign buf_we    = in_wr && ((state_q == IDLE) || (state_q == DONE));

  assign unused_bits = ^{mem_adr[1:0], mem_wdata[31:DW]};

  nn_input_buffer #(
    .N_IN (N_IN),
    .DW   (DW)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .we_i        (buf_we),
    .wr_idx_i    (buf_idx),
    .wdata_i     (mem_wdata[DW-1:0]),
    .core_idx_i  (buf_idx),
    .core_data_o (core_data),
    .nn_idx_i    (nn_rd_idx),
    .nn_data_o   (nn_rd_data)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN: begin
        // The engine cannot be aborted; any command or buffer write is flagged instead.
        if (in_wr || (ctrl_wr && (mem_wdata[CTRL_START] || mem_wdata[CTRL_CLEAR]))) begin
          err_d = 1'b1;
        end
        if (nn_done) begin
          state_d  = DONE;
          result_d = nn_result;
        end
      end
      DONE: begin
        if (clear_cmd) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else if (start_cmd) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign nn_start = start_q;
  assign status   = {22'b0, state_q, 5'b0, err_q, (state_q == DONE), (state_q == RUN)};

  always_comb begin
    mem_rdata = '0;
    if (mem_sel) begin
      if (in_hit) begin
        mem_rdata = 32'(core_data);
      end else if (word == STAT_OFS[7:2]) begin
        mem_rdata = status;
      end else if (word == RES_OFS[7:2]) begin
        mem_rdata = 32'(result_q);
      end
    end
  end

endmodule

// File: tb/tb_nn_mmio_bridge.sv
// Scoreboard bench for nn_mmio_bridge: directed scenarios followed by random traffic.
module tb_nn_mmio_bridge;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int NIN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_adr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_sel;
  logic        nn_start;
  logic [3:0]  nn_rd_idx = '0;
  logic [7:0]  nn_rd_data;
  logic        nn_done = 1'b0;
  logic [31:0] nn_result = '0;

  always #5 clk = ~clk;

  nn_mmio_bridge #(
    .BASE_ADDR (BASE),
    .N_IN      (NIN),
    .DW        (8),
    .RW        (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_sel    (mem_sel),
    .nn_start   (nn_start),
    .nn_rd_idx  (nn_rd_idx),
    .nn_rd_data (nn_rd_data),
    .nn_done    (nn_done),
    .nn_result  (nn_result)
  );

  // Kinds: 0 mem_rdata, 1 nn_start, 2 nn_rd_data, 3 mem_sel.
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;

  // Reference model: 0 idle, 1 running, 2 done.
  int          m_state;
  logic        m_err;
  logic        m_start;
  logic [31:0] m_result;
  logic [7:0]  m_buf [NIN];

  function automatic void push(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    logic [1:0] code;
    if (!model_hit(a)) return 32'h0;
    w = int'(a[7:0]) / 4;
    code = 2'(m_state);
    if (w == 1) return {22'b0, code, 5'b0, m_err, m_state == 2, m_state == 1};
    if (w == 2) return m_result;
    if (w >= 4 && w < 4 + NIN) return {24'b0, m_buf[w-4]};
    return 32'h0;
  endfunction

  function automatic void model_step();
    int   w;
    logic wen, ctrl, isin, st, cl, ns;
    if (!rst_n) begin
      m_state  = 0;
      m_err    = 1'b0;
      m_result = '0;
      m_start  = 1'b0;
      for (int i = 0; i < NIN; i++) m_buf[i] = '0;
      return;
    end
    wen  = mem_we && model_hit(mem_adr);
    w    = int'(mem_adr[7:0]) / 4;
    ctrl = wen && (w == 0);
    isin = wen && (w >= 4) && (w < 4 + NIN);
    st   = mem_wdata[0];
    cl   = mem_wdata[1];
    ns   = 1'b0;
    if (m_state == 0) begin
      if (isin) m_buf[w-4] = mem_wdata[7:0];
      if (ctrl && st && !cl) begin
        m_state = 1;
        ns = 1'b1;
      end
    end else if (m_state == 1) begin
      if (isin || (ctrl && (st || cl))) m_err = 1'b1;
      if (nn_done) begin
        m_state  = 2;
        m_result = nn_result;
      end
    end else begin
      if (isin) m_buf[w-4] = mem_wdata[7:0];
      if (ctrl && cl) begin
        m_state = 0;
        m_err   = 1'b0;
      end else if (ctrl && st) begin
        m_state = 1;
        ns = 1'b1;
      end
    end
    m_start = ns;
  endfunction

  // Queue the model's view of this cycle, then advance one clock.
  task automatic tick();
    if (chk_en) begin
      push(3, {31'b0, model_hit(mem_adr)}, "mem_sel");
      push(0, model_read(mem_adr), "mem_rdata");
      push(1, {31'b0, m_start}, "nn_start");
      push(2, {24'b0, m_buf[nn_rd_idx]}, "nn_rd_data");
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_adr   = BASE + {24'b0, ofs};
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic rdc(input logic [7:0] ofs, input logic [31:0] exp, input string name);
    mem_we  = 1'b0;
    mem_adr = BASE + {24'b0, ofs};
    push(0, exp, name);
    tick();
  endtask

  task automatic done_pulse(input logic [31:0] res);
    nn_done   = 1'b1;
    nn_result = res;
    tick();
    nn_done   = 1'b0;
  endtask

  // Monitor: compares everything queued for the current cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.kind)
        0:       act = mem_rdata;
        1:       act = {31'b0, nn_start};
        2:       act = {24'b0, nn_rd_data};
        default: act = {31'b0, mem_sel};
      endcase
      n_cmp++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s adr=%h actual=%h expected=%h t=%0t", it.name, mem_adr, act, it.exp,
                 $time);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    tick();
    chk_en = 1'b1;
    rdc(8'h04, 32'h0, "reset_status");
    rst_n = 1'b1;

    // First run.
    wr(8'h10, 32'h12);
    wr(8'h4C, 32'hFE);
    rdc(8'h4C, 32'hFE, "in15_read");
    wr(8'h00, 32'h1);
    nn_rd_idx = 4'd0;
    push(1, 32'h1, "start_pulse");
    push(2, 32'h12, "rd_idx0");
    rdc(8'h04, 32'h101, "status_run");
    push(1, 32'h0, "start_one_cycle");
    rdc(8'h04, 32'h101, "status_run2");

    // Completion and clear.
    done_pulse(32'hDEADBEEF);
    rdc(8'h04, 32'h202, "status_done");
    rdc(8'h08, 32'hDEADBEEF, "result");
    wr(8'h00, 32'h2);
    rdc(8'h04, 32'h0, "status_cleared");
    rdc(8'h08, 32'hDEADBEEF, "result_kept");

    // Errors while running.
    wr(8'h00, 32'h1);
    wr(8'h1C, 32'h55);
    push(1, 32'h0, "no_restart");
    wr(8'h00, 32'h1);
    push(1, 32'h0, "no_restart2");
    rdc(8'h1C, 32'h0, "in3_blocked");
    rdc(8'h04, 32'h105, "status_err");
    done_pulse(32'h11);
    rdc(8'h04, 32'h206, "status_done_err");
    wr(8'h00, 32'h2);
    rdc(8'h04, 32'h0, "status_clr_err");

    // Collisions and restart.
    wr(8'h00, 32'h3);
    push(1, 32'h0, "clear_wins");
    rdc(8'h04, 32'h0, "status_idle_clr");
    wr(8'h00, 32'h1);
    nn_done   = 1'b1;
    nn_result = 32'hCAFE;
    wr(8'h24, 32'h77);
    nn_done   = 1'b0;
    rdc(8'h04, 32'h206, "collision_done");
    rdc(8'h24, 32'h0, "in5_blocked");
    wr(8'h00, 32'h1);
    push(1, 32'h1, "restart_pulse");
    rdc(8'h04, 32'h105, "status_restart");
    rdc(8'h10, 32'h12, "buf_intact");

    // Reset while running.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(1, 32'h0, "rst_no_start");
    rdc(8'h04, 32'h0, "rst_status");
    rdc(8'h10, 32'h0, "rst_buf");
    done_pulse(32'h99);
    rdc(8'h04, 32'h0, "late_done_ignored");

    // Decode.
    mem_adr = BASE + 32'h100;
    push(3, 32'h0, "sel_outside");
    push(0, 32'h0, "rdata_outside");
    tick();
    rdc(8'h0C, 32'h0, "reserved_read");
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'hFFFF);
    rdc(8'h04, 32'h101, "reserved_no_err");
    done_pulse(32'h1);
    wr(8'h00, 32'h2);
    wr(8'h14, 32'h1234_5678);
    rdc(8'h14, 32'h78, "in1_truncated");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst_n     = ($urandom_range(0, 299) != 0);
      nn_done   = ($urandom_range(0, 7) == 0);
      nn_result = $urandom;
      nn_rd_idx = 4'($urandom_range(0, NIN - 1));
      mem_wdata = $urandom;
      r = $urandom_range(0, 9);
      mem_we = (r <= 6);
      if (r <= 3) begin
        mem_adr = BASE + 32'h10 + 32'($urandom_range(0, NIN - 1)) * 4;
      end else if (r <= 5) begin
        mem_adr   = BASE;
        mem_wdata = 32'($urandom_range(0, 3));
      end else if (r <= 7) begin
        mem_adr = BASE + 32'($urandom_range(0, 255));
      end else if (r == 8) begin
        mem_adr = ($urandom_range(0, 1) == 0) ? BASE + 32'h100 : $urandom;
      end else begin
        mem_adr = BASE + 32'h4;
      end
      mem_adr[1:0] = 2'($urandom_range(0, 3));
      tick();
    end

    rst_n   = 1'b1;
    mem_we  = 1'b0;
    nn_done = 1'b0;
    tick();
    chk_en = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
